// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register block: register offsets, decoded
// address width and the default pin count.
package gpio_pkg;

  localparam int GPIO_DEFAULT_GW = 32;

  // Word index taken from byte address bits [7:2]
  localparam int REG_IDX_W = 6;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam logic [7:0] GPIO_DATA_OUT = 8'h00;
  localparam logic [7:0] GPIO_DIR      = 8'h04;
  localparam logic [7:0] GPIO_DATA_IN  = 8'h08;
  localparam logic [7:0] GPIO_INT_EN   = 8'h0C;
  localparam logic [7:0] GPIO_INT_TYPE = 8'h10;
  localparam logic [7:0] GPIO_INT_POL  = 8'h14;
  localparam logic [7:0] GPIO_INT_STAT = 8'h18;

  function automatic reg_idx_t to_idx(input logic [7:0] byte_off);
    return byte_off[7:2];
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// GW-wide two-flop input synchronizer with an extra delay stage so callers
// can compare the current synchronized value (s2) against the previous one (s3).
module gpio_sync #(
  parameter int GW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] d,
  output logic [GW-1:0] s2,
  output logic [GW-1:0] s3
);

  logic [GW-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

endmodule

// File: rtl/gpio_regs.sv
// GPIO register file and pin control: output/direction registers, synchronized
// inputs, edge/level interrupt status and a registered interrupt request.
module gpio_regs
  import gpio_pkg::*;
#(
  parameter int GW = GPIO_DEFAULT_GW,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] reg_wdata_i,
  input  logic          reg_wen_i,
  input  logic          reg_ren_i,
  input  logic [AW-1:0] reg_addr_i,
  output logic [DW-1:0] reg_rdata_o,
  input  logic [GW-1:0] gpio_i,
  output logic [GW-1:0] gpio_o,
  output logic [GW-1:0] gpio_oe_o,
  output logic          irq_o
);

  reg_idx_t      addr_idx;
  logic [GW-1:0] wdata;

  logic [GW-1:0] data_out;
  logic [GW-1:0] dir;
  logic [GW-1:0] int_en;
  logic [GW-1:0] int_type;
  logic [GW-1:0] int_pol;
  logic [GW-1:0] int_stat;

  logic [GW-1:0] s2;
  logic [GW-1:0] s3;
  logic [GW-1:0] evt;
  logic [GW-1:0] lvl;
  logic [GW-1:0] w1c;
  logic [GW-1:0] stat_nxt;

  logic we_data_out;
  logic we_dir;
  logic we_int_en;
  logic we_int_type;
  logic we_int_pol;
  logic we_int_stat;

  assign addr_idx = reg_addr_i[7:2];
  assign wdata    = reg_wdata_i[GW-1:0];

  // Read strobe and undecoded address bits carry no function here
  logic unused_bits;
  assign unused_bits = ^{reg_ren_i, reg_addr_i[AW-1:8], reg_addr_i[1:0]};

  if (DW > GW) begin : g_wide_bus
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata_i[DW-1:GW];
  end

  gpio_sync #(
    .GW (GW)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .s2  (s2),
    .s3  (s3)
  );

  always_comb begin
    we_data_out = 1'b0;
    we_dir      = 1'b0;
    we_int_en   = 1'b0;
    we_int_type = 1'b0;
    we_int_pol  = 1'b0;
    we_int_stat = 1'b0;
    if (reg_wen_i) begin
      unique case (addr_idx)
        to_idx(GPIO_DATA_OUT): we_data_out = 1'b1;
        to_idx(GPIO_DIR):      we_dir      = 1'b1;
        to_idx(GPIO_INT_EN):   we_int_en   = 1'b1;
        to_idx(GPIO_INT_TYPE): we_int_type = 1'b1;
        to_idx(GPIO_INT_POL):  we_int_pol  = 1'b1;
        to_idx(GPIO_INT_STAT): we_int_stat = 1'b1;
        default: ;
      endcase
    end
  end

  // Edge bits are sticky with set winning over W1C; level bits track the pin.
  assign evt      = int_type & ((s2 & ~s3 & int_pol) | (~s2 & s3 & ~int_pol));
  assign lvl      = ~(s2 ^ int_pol);
  assign w1c      = we_int_stat ? wdata : '0;
  assign stat_nxt = (int_type & ((int_stat & ~w1c) | evt)) | (~int_type & lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      dir      <= '0;
      int_en   <= '0;
      int_type <= '0;
      int_pol  <= '0;
      int_stat <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (we_data_out) data_out <= wdata;
      if (we_dir)      dir      <= wdata;
      if (we_int_en)   int_en   <= wdata;
      if (we_int_type) int_type <= wdata;
      if (we_int_pol)  int_pol  <= wdata;
      int_stat <= stat_nxt;
      irq_o    <= |(int_stat & int_en);
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    unique case (addr_idx)
      to_idx(GPIO_DATA_OUT): reg_rdata_o = DW'(data_out);
      to_idx(GPIO_DIR):      reg_rdata_o = DW'(dir);
      to_idx(GPIO_DATA_IN):  reg_rdata_o = DW'(s2);
      to_idx(GPIO_INT_EN):   reg_rdata_o = DW'(int_en);
      to_idx(GPIO_INT_TYPE): reg_rdata_o = DW'(int_type);
      to_idx(GPIO_INT_POL):  reg_rdata_o = DW'(int_pol);
      to_idx(GPIO_INT_STAT): reg_rdata_o = DW'(int_stat);
      default:               reg_rdata_o = '0;
    endcase
  end

  assign gpio_o    = data_out;
  assign gpio_oe_o = dir;

endmodule

// File: doc/gpio_regs.md
# gpio_regs

GPIO register file and pin-control core. Sits directly downstream of the GPIO APB slave and consumes its register-interface strobes (write/read enable, address, write data). It returns read data combinationally. Internally it holds the output, direction and interrupt-configuration registers, synchronizes the input pins and detects edge/level interrupt events. It drives the pad-side output, output-enable and a registered interrupt request.

## Interface
Parameters:
- GW, 32, number of GPIO pins (1..32)
- AW, 32, register address width
- DW, 32, register data width

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- reg_wdata_i  input  DW  write data from the APB slave
- reg_wen_i  input  1  write strobe; one cycle per APB access phase
- reg_ren_i  input  1  read strobe; informational only, does not gate read data
- reg_addr_i  input  AW  byte address; only bits [7:2] are decoded
- reg_rdata_o  output  DW  read data, combinational from reg_addr_i
- gpio_i  input  GW  asynchronous pad inputs
- gpio_o  output  GW  pad output values (DATA_OUT register)
- gpio_oe_o  output  GW  pad output enables (DIR register, 1 = output)
- irq_o  output  1  interrupt request, registered, level-high

## Operation
- Register map (offset / access / reset value):
  - 0x00 DATA_OUT / RW / 0
  - 0x04 DIR / RW / 0
  - 0x08 DATA_IN / RO / 0
  - 0x0C INT_EN / RW / 0
  - 0x10 INT_TYPE / RW / 0; 1 = edge, 0 = level
  - 0x14 INT_POL / RW / 0; 1 = rising/high, 0 = falling/low
  - 0x18 INT_STAT / RW1C / 0
- Offsets 0x1C–0xFC read 0 and ignore writes. Bits [GW..DW-1] read 0 and ignore writes.
- Writes:
  - Committed on the rising clk edge where reg_wen_i = 1.
  - Writes to DATA_IN are ignored.
  - INT_STAT: writing 1 clears an edge-mode bit; writing 0 has no effect.
- Input path: gpio_i passes through 2 synchronizer flops (s1, s2). A third flop, s3, holds the previous value of s2. DATA_IN = s2.
- Event detection, per bit i, evaluated every cycle:
  - Edge mode: evt = INT_POL ? (s2 & ~s3) : (~s2 & s3). INT_STAT[i] is sticky: set on evt, cleared only by W1C.
  - Level mode: INT_STAT[i] <= (s2 == INT_POL) every cycle. W1C has no effect.
  - Edge-mode event and W1C of the same bit in the same cycle: the set wins, so the bit stays 1.
  - Switching INT_TYPE from edge to level: the bit follows the level from the next cycle. Switching from level to edge: the bit keeps its current value until cleared.
- irq_o <= |(INT_STAT & INT_EN), registered.
- Interrupt events are detected and INT_STAT updates regardless of INT_EN. INT_EN masks only irq_o.
- DIR does not gate the input path. Output pins also read back through DATA_IN.

## Timing
- Reset:
  - rst asserted clears all registers, synchronizer flops and irq_o immediately, without waiting for a clock edge.
  - Outputs under reset: gpio_o = 0, gpio_oe_o = 0, irq_o = 0, reg_rdata_o = 0 for every address.
  - Reset asserted mid-operation discards any pending event. No interrupt is generated by the first synchronized values after reset release, because s2 = s3 = 0.
- Write-to-output latency: gpio_o and gpio_oe_o change on the same edge that commits the write.
- Read latency: 0 cycles. reg_rdata_o reflects register state and reg_addr_i in the current cycle. A write and a read in the same cycle cannot occur on APB.
- gpio_i to DATA_IN latency: 2 edges.
- gpio_i edge to INT_STAT set: 3 edges.
- INT_STAT set to irq_o high: 1 further edge, 4 edges total.
- W1C to irq_o low: INT_STAT clears on the write edge and irq_o drops on the next edge.
- Pulses shorter than 1 clk period may be missed; this is specified behaviour.

## Structure
- Package gpio_pkg holds:
  - offset constants GPIO_DATA_OUT through GPIO_INT_STAT
  - the decoded-address width constant (6 bits, [7:2])
  - default GW
- Sub-module gpio_sync: GW-wide 2-flop synchronizer plus the delay flop, with outputs s2 and s3. It is also reused by future pad blocks.
- Register file, decode, event logic and irq flop live in gpio_regs.

## Test plan
- Reset values: assert rst mid-cycle → all outputs 0 immediately. Read every offset 0x00–0x18 → 0.
- RW and readback: write DIR = 0x0000_00FF and DATA_OUT = 0xA5A5_A5A5 → gpio_oe_o = 0xFF and gpio_o = 0xA5A5_A5A5 on the commit edge. Reads return the same values. Write 0x08 → DATA_IN unchanged. Read 0x40 → 0.
- Rising edge interrupt: INT_TYPE = 1, INT_POL = 1, INT_EN = 1; drive gpio_i[0] 0→1 → DATA_IN[0] = 1 after 2 edges, INT_STAT = 0x1 after 3 edges, irq_o = 1 after 4 edges. W1C 0x1 → INT_STAT = 0, irq_o = 0 one edge later.
- Level interrupt: INT_TYPE = 0, INT_POL = 0, INT_EN bit 3 set; hold gpio_i[3] = 0 → INT_STAT[3] = 1 and cannot be cleared by W1C. Drive gpio_i[3] = 1 → INT_STAT[3] = 0 three edges later.
- Collision: falling-edge mode on bit 5; time the W1C so it lands on the same edge as the detected event → INT_STAT[5] remains 1.
- Masking: event on bit 7 with INT_EN = 0 → INT_STAT[7] = 1, irq_o stays 0. Then write INT_EN = 0x80 → irq_o = 1 one edge after the write.
